epbuf_dma: RTL
==============

# epbuf_dma

Wishbone-master DMA engine that moves 32-bit words between the USB endpoint buffer and any Wishbone slave, such as SPRAM or a peripheral FIFO. It sits beside the CPU-facing endpoint-buffer bridge. It drives the same EP-buf TX write and RX read ports, but as a bus initiator rather than a responder, so packet payloads are copied without CPU word-by-word access. Firmware (or a control register block) programs a transfer and then waits for `done`.

## Interface
Parameters:
- `AW`, 9: EP-buf word address width.
- `DW`, 32: data width; must be 32.
- `WAW`, 16: Wishbone word address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cmd_start`  in  1  one-cycle pulse; latches the `cmd_*` fields.
- `cmd_dir`  in  1  transfer direction.
  - 0 = EP-buf RX to Wishbone write.
  - 1 = Wishbone read to EP-buf TX.
- `cmd_ep_addr`  in  AW  first EP-buf word address.
- `cmd_wb_addr`  in  WAW  first Wishbone word address.
- `cmd_len`  in  AW+1  word count; 0 is legal.
- `cmd_abort`  in  1  stop after the current word.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  sticky; set when a transfer ended by abort, cleared by `cmd_start`.
- `xfer_cnt`  out  AW+1  words completed in the current or last transfer.
- `wbm_addr`  out  WAW  Wishbone address.
- `wbm_wdata`  out  DW  Wishbone write data.
- `wbm_rdata`  in  DW  Wishbone read data.
- `wbm_we`  out  1  Wishbone write enable.
- `wbm_cyc`  out  1  Wishbone cycle; also acts as strobe.
- `wbm_ack`  in  1  Wishbone acknowledge.
- `ep_tx_addr_0`  out  AW  EP-buf TX address.
- `ep_tx_data_0`  out  DW  EP-buf TX data.
- `ep_tx_we_0`  out  1  EP-buf TX write enable.
- `ep_rx_addr_0`  out  AW  EP-buf RX address.
- `ep_rx_data_1`  in  DW  EP-buf RX data; valid 1 cycle after address plus `ep_rx_re_0`.
- `ep_rx_re_0`  out  1  EP-buf RX read enable.

## Operation
States: IDLE, EP_RD, EP_LAT, WB_CYC, EP_WR, FIN.

- **IDLE:**
  - `cmd_start` latches the address and length registers, clears `xfer_cnt` and `aborted`, and sets `busy`.
  - `cmd_len`=0 goes to FIN.
  - Otherwise, `cmd_dir`=0 goes to EP_RD; `cmd_dir`=1 goes to WB_CYC.
- **dir 0, per word:**
  - EP_RD: `ep_rx_re_0`=1 with `ep_rx_addr_0`=current EP address.
  - EP_LAT: captures `ep_rx_data_1` into the data register.
  - WB_CYC: `wbm_cyc`=1, `wbm_we`=1, `wbm_wdata`=data register; stays until `wbm_ack`.
- **dir 1, per word:**
  - WB_CYC: `wbm_cyc`=1, `wbm_we`=0; on `wbm_ack`, captures `wbm_rdata`.
  - EP_WR: `ep_tx_we_0`=1 for exactly one cycle with `ep_tx_addr_0`/`ep_tx_data_0` from registers.
- **Word completion** (ack in dir 0, EP_WR in dir 1):
  - `xfer_cnt`+1; EP address +1 (wraps mod 2^AW); Wishbone address +1 (wraps mod 2^WAW); remaining count −1.
  - If remaining is 0 or abort is pending, go to FIN; else start the next word.
- **FIN:** `done`=1 for one cycle, `busy`=0, return to IDLE.
- **Abort:** `cmd_abort` in any busy cycle sets an internal abort-pending flag.
  - The current word always completes; no half-cycle abandonment on Wishbone.
  - `aborted`=1 at FIN.
  - `cmd_abort` in IDLE is ignored.
- **Wishbone rules:**
  - `wbm_addr`, `wbm_we` and `wbm_wdata` stay stable while `wbm_cyc`=1.
  - `wbm_cyc` drops in the cycle after ack and stays low at least one cycle between words.
  - Ack with `wbm_cyc`=0 is ignored.
- **Start while busy:** `cmd_start` is ignored. `cmd_start` and `cmd_abort` in the same IDLE cycle: start wins, abort is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `ep_rx_re_0`=0.
- Reset mid-transfer drops `wbm_cyc` and `ep_tx_we_0` asynchronously; no `done` pulse.
- dir 0: 3 + W cycles per word, where W = cycles from `wbm_cyc` rise to `wbm_ack`. W=1 for a registered-ack slave, so 4 cycles per word.
- dir 1: 2 + W cycles per word.
- `busy` rises the cycle after `cmd_start`. `done` appears the cycle after the last word completes; `busy` falls with `done`.
- `cmd_len`=0: `done` 2 cycles after `cmd_start`, with zero bus activity.

## Configuration
- `EPBUF_DMA_BYTESWAP_EN` defined:
  - Every word is byte-reversed in both directions: data {b3,b2,b1,b0} becomes {b0,b1,b2,b3}.
  - The swap is applied at the capture of the data register.
  - No added latency.
- Undefined: data passes unmodified.

## Test plan
- **dir 0, 4 words:** `cmd_ep_addr`=0x010, `cmd_wb_addr`=0x2000, EP RX model returns 0xA0000000+addr, slave acks 1 cycle after cyc.
  - Writes 0xA0000010..0xA0000013 to 0x2000..0x2003.
  - `done` once, `xfer_cnt`=4, 16 busy cycles.
- **dir 1, 3 words, wait states:** slave inserts 2 wait states and returns 0x11223344, 0x55667788, 0x99AABBCC.
  - Exactly three one-cycle TX writes to EP addresses 0x1FF, 0x000, 0x001; EP address wraps.
- **Abort:** `cmd_abort` during word 2 of an 8-word transfer.
  - Word 2 completes; `xfer_cnt`=2, `aborted`=1, `done` pulse.
  - `wbm_cyc` never truncated before ack.
- **Zero length and ignored start:** `cmd_len`=0 gives `done` after 2 cycles, `wbm_cyc`/`ep_*` never asserted.
  - `cmd_start` while busy leaves the latched addresses unchanged.
- **Reset mid-transfer:** `rst_n` low while `wbm_cyc`=1 deasserts all outputs immediately.
  - After release, a new 1-word transfer completes normally.
- **With `EPBUF_DMA_BYTESWAP_EN`:** dir 0 RX word 0x01020304 is written to Wishbone as 0x04030201.

Source files
------------

// File: rtl/epbuf_dma.sv
// epbuf_dma: Wishbone-master DMA between the USB endpoint buffer and any Wishbone slave.
// Optional build macro EPBUF_DMA_BYTESWAP_EN byte-reverses every word as it is captured.
module epbuf_dma #(
  parameter int unsigned AW  = 9,
  parameter int unsigned DW  = 32,
  parameter int unsigned WAW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_start,
  input  logic            cmd_dir,
  input  logic [AW-1:0]   cmd_ep_addr,
  input  logic [WAW-1:0]  cmd_wb_addr,
  input  logic [AW:0]     cmd_len,
  input  logic            cmd_abort,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [AW:0]     xfer_cnt,
  output logic [WAW-1:0]  wbm_addr,
  output logic [DW-1:0]   wbm_wdata,
  input  logic [DW-1:0]   wbm_rdata,
  output logic            wbm_we,
  output logic            wbm_cyc,
  input  logic            wbm_ack,
  output logic [AW-1:0]   ep_tx_addr_0,
  output logic [DW-1:0]   ep_tx_data_0,
  output logic            ep_tx_we_0,
  output logic [AW-1:0]   ep_rx_addr_0,
  input  logic [DW-1:0]   ep_rx_data_1,
  output logic            ep_rx_re_0
);

  typedef enum logic [2:0] {IDLE, EP_RD, EP_LAT, WB_CYC, EP_WR, FIN} state_t;

  state_t         state_q;
  logic           dir_q, busy_q, done_q, aborted_q, pend_q;
  logic           cyc_q, we_q, re_q, txwe_q;
  logic [AW-1:0]  ep_addr_q, ep_addr_d;
  logic [WAW-1:0] wb_addr_q, wb_addr_d;
  logic [AW:0]    rem_q, rem_d, cnt_q, cnt_d;
  logic [DW-1:0]  data_q;
  logic           word_done, last_word;

  function automatic logic [DW-1:0] fmt(input logic [DW-1:0] w);
`ifdef EPBUF_DMA_BYTESWAP_EN
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DW/8; i++)
      r[8*i +: 8] = w[DW-8-8*i +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  always_comb begin
    word_done = ((state_q == WB_CYC) && wbm_ack && !dir_q) || (state_q == EP_WR);
    last_word = (rem_q == (AW+1)'(1)) || pend_q || cmd_abort;
    ep_addr_d = ep_addr_q + AW'(1);
    wb_addr_d = wb_addr_q + WAW'(1);
    rem_d     = rem_q - (AW+1)'(1);
    cnt_d     = cnt_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pend_q    <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      txwe_q    <= 1'b0;
      ep_addr_q <= '0;
      wb_addr_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
    end else begin
      if (busy_q && cmd_abort) pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            ep_addr_q <= cmd_ep_addr;
            wb_addr_q <= cmd_wb_addr;
            rem_q     <= cmd_len;
            dir_q     <= cmd_dir;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b1;
            if (cmd_len == '0) begin
              state_q <= FIN;
            end else if (!cmd_dir) begin
              state_q <= EP_RD;
              re_q    <= 1'b1;
            end else begin
              state_q <= WB_CYC;
              cyc_q   <= 1'b1;
              we_q    <= 1'b0;
            end
          end
        end
        EP_RD: begin
          re_q    <= 1'b0;
          state_q <= EP_LAT;
        end
        EP_LAT: begin
          data_q  <= fmt(ep_rx_data_1);
          cyc_q   <= 1'b1;
          we_q    <= 1'b1;
          state_q <= WB_CYC;
        end
        WB_CYC: begin
          if (wbm_ack) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            if (dir_q) begin
              data_q  <= fmt(wbm_rdata);
              txwe_q  <= 1'b1;
              state_q <= EP_WR;
            end
          end
        end
        EP_WR: txwe_q <= 1'b0;
        FIN: begin
          // Word completion enters FIN with done already set; the zero-length
          // path arrives with done clear and spends one extra busy cycle here.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            aborted_q <= pend_q | cmd_abort;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (word_done) begin
        cnt_q     <= cnt_d;
        ep_addr_q <= ep_addr_d;
        wb_addr_q <= wb_addr_d;
        rem_q     <= rem_d;
        if (last_word) begin
          state_q   <= FIN;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          aborted_q <= pend_q | cmd_abort;
        end else if (dir_q) begin
          state_q <= WB_CYC;
          cyc_q   <= 1'b1;
        end else begin
          state_q <= EP_RD;
          re_q    <= 1'b1;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign xfer_cnt     = cnt_q;
  assign wbm_addr     = wb_addr_q;
  assign wbm_wdata    = data_q;
  assign wbm_we       = we_q;
  assign wbm_cyc      = cyc_q;
  assign ep_tx_addr_0 = ep_addr_q;
  assign ep_tx_data_0 = data_q;
  assign ep_tx_we_0   = txwe_q;
  assign ep_rx_addr_0 = ep_addr_q;
  assign ep_rx_re_0   = re_q;

endmodule
